mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU engine attached to the execute stage.
//  Execute raises start with stable operands; the unit produces {hi,lo} and a one-cycle done
//  that execute forwards as mult_ok to hazard. Hazard holds stallE while the op is pending.
//  Results flow via execute_data_t -> mreg -> writeback hi_req/lo_req.
// PARAMETERS
//  MUL_LAT     2   cycles from start sample to done for MULT/MULTU (>=1); product pipeline depth
//  DIV_CYCLES  32  iteration count of restoring divider (fixed 32 for 32-bit operands)
// PORTS
//  clk    in   1   clock, rising edge
//  reset  in   1   asynchronous, active-high reset
//  start  in   1   request; sampled only in IDLE; a, b, op must stay stable until done
//  op     in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a      in   32  rs operand (multiplicand / dividend)
//  b      in   32  rt operand (multiplier / divisor)
//  flush  in   1   synchronous abort (flushE / exception); kills the in-flight op
//  hi     out  32  product[63:32] or remainder; held until next done
//  lo     out  32  product[31:0] or quotient; held until next done
//  done   out  1   one-cycle pulse, hi/lo valid in the same cycle (mult_ok)
//  busy   out  1   high in MUL, DIV, FIX states
// BEHAVIOUR
//  Reset (async): state=IDLE, hi=lo=0, done=0, busy=0, all internal counters/regs cleared.
//  States: IDLE, MUL, DIV, FIX, DONE.
//   IDLE: start&!flush & op[1]=0 -> MUL (cnt=1); start&!flush & op[1]=1 -> DIV (cnt=0).
//         Capture |a|,|b| (signed ops) or a,b (unsigned) plus result-sign flags at sample.
//   MUL:  full 64-bit product computed at sample, shifted through MUL_LAT-1 register stages;
//         cnt==MUL_LAT-1 -> DONE (hi/lo loaded on that edge).
//   DIV:  restoring, one quotient bit per cycle: rem={rem[30:0],dvd[31]}; if rem>=dvs
//         then rem-=dvs, qbit=1. 33-bit compare, no carry loss. cnt==DIV_CYCLES-1 -> FIX.
//   FIX:  signed DIV: quotient negated if sign(a)!=sign(b); remainder takes sign(a).
//         lo=quotient, hi=remainder loaded; -> DONE.
//   DONE: done=1 for exactly this cycle; -> IDLE unconditionally. A start seen in IDLE on the
//         next cycle begins a new op (back-to-back muls are separate requests).
//  Latency (start-sample cycle = 0): MULT/MULTU done in cycle MUL_LAT; DIV/DIVU done in
//   cycle DIV_CYCLES+2 (34 at defaults). start ignored outside IDLE.
//  Signed mult: two's-complement 64-bit product (sign-fix of |a|*|b| or native signed mult,
//   same result). Width: product 64 bits, hi=[63:32], lo=[31:0].
//  Divide by zero (b==0): no trap; runs full latency; lo=32'hFFFF_FFFF, hi=a (signed and
//   unsigned alike; sign fix suppressed).
//  Overflow DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (falls out of abs/negate).
//  flush: any state except IDLE -> IDLE next edge; done stays 0; hi/lo keep previous values.
//   flush in IDLE with start: no op begins. flush in DONE cycle: done still seen this cycle
//   (already committed), state -> IDLE.
//  Reset mid-operation: immediate IDLE and cleared outputs regardless of state.
//  busy=0 in IDLE and DONE; done never asserted while busy=1.
// TESTING
//  MULT a=0xFFFF_FFFD b=5 -> done at cycle 2, hi=0xFFFF_FFFF lo=0xFFFF_FFF1.
//  MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE lo=0x0000_0001; busy high cycles 1..1.
//  DIV a=0xFFFF_FFF9(-7) b=2 -> done at cycle 34, lo=0xFFFF_FFFD hi=0xFFFF_FFFF;
//   DIVU a=100 b=7 -> lo=14 hi=2; DIV 0x8000_0000/-1 -> lo=0x8000_0000 hi=0.
//  DIVU a=5 b=0 -> cycle 34 done, lo=0xFFFF_FFFF hi=5.
//  DIV started, flush at cycle 10 -> busy=0 from cycle 11, no done, hi/lo unchanged;
//   start again cycle 12 -> correct result at cycle 46.
//  reset pulsed mid-DIV at cycle 20 -> hi=lo=0, done=0, busy=0 immediately; back-to-back
//   MULT,MULT with start held -> two done pulses at cycles 2 and 5.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage.
// Produces {hi,lo} with a one-cycle done pulse; flush aborts.
module mult_div_unit #(
  parameter int MUL_LAT    = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] pipe_q [PD];
  logic [31:0] hi_q, lo_q;
  logic [31:0] dvd_q, dvs_q, rem_q;
  logic        negq_q, negr_q;

  logic        sgn, go;
  logic [31:0] a_abs, b_abs;
  logic [63:0] ea, eb, prod;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_d;
  logic [31:0] quo_fix, rem_fix;

  assign sgn   = ~op[0];
  assign go    = start & ~flush;
  assign a_abs = (sgn & a[31]) ? -a : a;
  assign b_abs = (sgn & b[31]) ? -b : b;

  // Low 64 bits of the sign-extended product are exact for both MULT and MULTU
  assign ea   = {{32{sgn & a[31]}}, a};
  assign eb   = {{32{sgn & b[31]}}, b};
  assign prod = ea * eb;

  assign rem_sh = {rem_q, dvd_q[31]};
  assign ge     = rem_sh >= {1'b0, dvs_q};
  assign rem_d  = ge ? 32'(rem_sh - {1'b0, dvs_q})
                     : rem_sh[31:0];

  assign quo_fix = negq_q ? -dvd_q : dvd_q;
  assign rem_fix = negr_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (!op[1]) begin
            state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
            cnt_d   = 8'd1;
          end else begin
            state_d = S_DIV;
            cnt_d   = 8'd0;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == 8'(MUL_LAT - 1)) state_d = S_DONE;
        else cnt_d = cnt_q + 8'd1;
      end
      S_DIV: begin
        if (cnt_q == 8'(DIV_CYCLES - 1)) state_d = S_FIX;
        else cnt_d = cnt_q + 8'd1;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PD; i++) pipe_q[i] <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            pipe_q[0] <= prod;
            if (MUL_LAT == 1 && !op[1]) {hi_q, lo_q} <= prod;
            dvd_q  <= a_abs;
            dvs_q  <= b_abs;
            rem_q  <= '0;
            // Divide-by-zero keeps the all-ones quotient unsigned
            negq_q <= sgn & (a[31] ^ b[31]) & (b != '0);
            negr_q <= sgn & a[31];
          end
        end
        S_MUL: begin
          for (int i = 1; i < PD; i++) pipe_q[i] <= pipe_q[i-1];
          if (!flush && cnt_q == 8'(MUL_LAT - 1))
            {hi_q, lo_q} <= pipe_q[PD-1];
        end
        S_DIV: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[30:0], ge};
        end
        S_FIX: begin
          if (!flush) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = (state_q == S_DONE);
  assign busy = (state_q == S_MUL) || (state_q == S_DIV) ||
                (state_q == S_FIX);

endmodule
